// File: rtl/salamander_pkg.sv
// rtl/salamander_pkg.sv - shared opcode, state and instruction types for the control unit
//
// Contents:
//   op_code_t   4-bit instruction opcodes (ALU ops 0..A, ST, control ops C..F)
//   cu_state_t  sequencer states FETCH/DECODE/EXECUTE/HALT
//   instr_t     packed instruction word {opcode, operand}
//   is_alu_op   opcode writes the accumulator (ADD..SHR, LD)
//   updates_carry  opcode loads carry_flag from the ALU
package salamander_pkg;

  localparam int CU_ADDR_WIDTH = 4;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_INC = 4'h2,
    OP_DEC = 4'h3,
    OP_AND = 4'h4,
    OP_OR  = 4'h5,
    OP_XOR = 4'h6,
    OP_NOT = 4'h7,
    OP_SHL = 4'h8,
    OP_SHR = 4'h9,
    OP_LD  = 4'hA,
    OP_ST  = 4'hB,
    OP_HLT = 4'hC,
    OP_JMP = 4'hD,
    OP_RTN = 4'hE,
    OP_NOP = 4'hF
  } op_code_t;

  typedef enum logic [1:0] {
    CU_FETCH   = 2'd0,
    CU_DECODE  = 2'd1,
    CU_EXECUTE = 2'd2,
    CU_HALT    = 2'd3
  } cu_state_t;

  typedef struct packed {
    op_code_t                 opcode;
    logic [CU_ADDR_WIDTH-1:0] operand;
  } instr_t;

  // Opcodes 0..A all route the ALU result into the accumulator.
  function automatic logic is_alu_op(op_code_t op);
    return op <= OP_LD;
  endfunction

  function automatic logic updates_carry(op_code_t op);
    return op inside {OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_SHL, OP_SHR};
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - program ROM, ALU and register-file bus of the control unit
//
// master (control unit): drives prog_addr, alu_ce, alu_op_code, alu_carry_in,
//                        acc_we, rf_addr, rf_we; samples prog_data,
//                        alu_carry_out, alu_op_out
// slave  (ROM/ALU/RF side): the mirror image
interface control_unit_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0] prog_addr;
  logic [ADDR_WIDTH+3:0] prog_data;
  logic                  alu_ce;
  logic [3:0]            alu_op_code;
  logic                  alu_carry_in;
  logic                  alu_carry_out;
  logic [DATA_WIDTH-1:0] alu_op_out;
  logic                  acc_we;
  logic [ADDR_WIDTH-1:0] rf_addr;
  logic                  rf_we;

  modport master (
    output prog_addr, alu_ce, alu_op_code, alu_carry_in, acc_we, rf_addr, rf_we,
    input  prog_data, alu_carry_out, alu_op_out
  );

  modport slave (
    input  prog_addr, alu_ce, alu_op_code, alu_carry_in, acc_we, rf_addr, rf_we,
    output prog_data, alu_carry_out, alu_op_out
  );
endinterface

// File: rtl/return_stack.sv
// rtl/return_stack.sv - small LIFO holding return addresses
//
// Ports: CLK, RST (async, active-high); push/push_data store an entry,
// pop discards the top entry; pop_data shows the current top; full/empty
// report occupancy. A push while full and a pop while empty are ignored.
module return_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    count;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  // Only meaningful when not empty; the caller checks empty first.
  assign pop_data = mem[IW'(count - CW'(1))];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + CW'(1);
    end else if (pop && !empty) begin
      count <= count - CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (push && !full) begin
      mem[IW'(count)] <= push_data;
    end
  end
endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - fetch/decode/execute sequencer driving the ALU and register file
//
// Ports: CLK, RST (async, active-high); bus (control_unit_if.master) carries
// the ROM address/data, ALU enable/opcode/carry and accumulator/register-file
// strobes; carry_flag/zero_flag are the registered ALU flags; halted is high
// from the HLT execute cycle onward; stack_ovf/stack_unf are sticky
// return-stack errors.
// Optional feature: define CU_RETURN_STACK_EN to make JMP push PC+1 and RTN
// pop it; otherwise RTN is a NOP and the stack flags are tied low.
module control_unit
  import salamander_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  control_unit_if.master       bus,
  output logic                 carry_flag,
  output logic                 zero_flag,
  output logic                 halted,
  output logic                 stack_ovf,
  output logic                 stack_unf
);
  localparam logic [1:0] S_FETCH   = CU_FETCH;
  localparam logic [1:0] S_DECODE  = CU_DECODE;
  localparam logic [1:0] S_EXECUTE = CU_EXECUTE;
  localparam logic [1:0] S_HALT    = CU_HALT;

  if (STACK_DEPTH < 1) begin : g_bad_depth
    $error("control_unit: STACK_DEPTH must be at least 1");
  end

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] pc_next;
  op_code_t              ir_opcode;
  logic [ADDR_WIDTH-1:0] ir_operand;
  logic                  exec;

  assign exec   = (state == S_EXECUTE);
  assign pc_inc = pc + ADDR_WIDTH'(1);

  // Strobes are decoded from state, so an async reset kills them at once.
  assign bus.prog_addr    = pc;
  assign bus.alu_op_code  = ir_opcode;
  assign bus.rf_addr      = ir_operand;
  assign bus.alu_carry_in = carry_flag;
  assign bus.acc_we       = exec && is_alu_op(ir_opcode);
  assign bus.rf_we        = exec && (ir_opcode == OP_ST);
  assign bus.alu_ce       = bus.acc_we || bus.rf_we;
  // Reported already in the HLT execute cycle, not only once in HALT.
  assign halted           = (state == S_HALT) || (exec && (ir_opcode == OP_HLT));

`ifdef CU_RETURN_STACK_EN
  logic                  push;
  logic                  pop;
  logic                  stk_full;
  logic                  stk_empty;
  logic [ADDR_WIDTH-1:0] stk_top;

  assign push = exec && (ir_opcode == OP_JMP);
  assign pop  = exec && (ir_opcode == OP_RTN);

  return_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_WIDTH)
  ) u_return_stack (
    .CLK       (CLK),
    .RST       (RST),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .pop_data  (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stack_ovf <= 1'b0;
      stack_unf <= 1'b0;
    end else begin
      if (push && stk_full) stack_ovf <= 1'b1;
      if (pop && stk_empty) stack_unf <= 1'b1;
    end
  end
`else
  assign stack_ovf = 1'b0;
  assign stack_unf = 1'b0;
`endif

  always_comb begin
    pc_next = pc_inc;
    case (ir_opcode)
      OP_HLT: pc_next = pc;
      OP_JMP: pc_next = ir_operand;
`ifdef CU_RETURN_STACK_EN
      OP_RTN: pc_next = stk_empty ? pc_inc : stk_top;
`endif
      default: pc_next = pc_inc;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= S_FETCH;
      pc         <= '0;
      ir_opcode  <= OP_NOP;
      ir_operand <= '0;
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
    end else begin
      case (state)
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          ir_opcode  <= op_code_t'(bus.prog_data[ADDR_WIDTH+3 -: 4]);
          ir_operand <= bus.prog_data[ADDR_WIDTH-1:0];
          state      <= S_EXECUTE;
        end
        S_EXECUTE: begin
          pc <= pc_next;
          if (is_alu_op(ir_opcode)) zero_flag <= (bus.alu_op_out == DATA_WIDTH'(0));
          if (updates_carry(ir_opcode)) carry_flag <= bus.alu_carry_out;
          state <= (ir_opcode == OP_HLT) ? S_HALT : S_FETCH;
        end
        default: state <= S_HALT;
      endcase
    end
  end
endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - self-checking bench for control_unit
module tb_control_unit;
  import salamander_pkg::*;

`ifdef CU_RETURN_STACK_EN
  localparam bit RS = 1'b1;
`else
  localparam bit RS = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic carry_flag, zero_flag, halted, stack_ovf, stack_unf;

  control_unit_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  control_unit #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .STACK_DEPTH(4)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .bus        (bus),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .halted     (halted),
    .stack_ovf  (stack_ovf),
    .stack_unf  (stack_unf)
  );

  always #5 CLK = ~CLK;

  // Synchronous program ROM: data valid one cycle after the address.
  logic [7:0] rom [16];
  always @(posedge CLK) bus.prog_data <= rom[bus.prog_addr];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit sb_en    = 1'b0;
  logic [3:0] exp_pc_q [$];

  typedef struct {
    logic [7:0] instr;
    bit         pre_c, pre_z;
    logic [7:0] op_out;
    bit         cout;
    bit         e_ce, e_acc, e_rf, e_halt;
    logic [3:0] e_pc;
    bit         e_c, e_z, e_unf;
  } vec_t;
  vec_t vecs [$];
  vec_t v;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] mk(op_code_t op, logic [3:0] a);
    instr_t i;
    i.opcode  = op;
    i.operand = a;
    return i;
  endfunction

  // Scoreboard: one expected fetch address per 3-cycle instruction slot.
  task automatic sb_sample();
    if (sb_en && (cyc % 3 == 0) && exp_pc_q.size() > 0)
      chk("fetch_addr", bus.prog_addr, exp_pc_q.pop_front());
  endtask

  task automatic step();
    @(negedge CLK);
    cyc++;
    sb_sample();
  endtask

  task automatic run_to(input int k);
    while (cyc < k) step();
  endtask

  task automatic start();
    RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    cyc = 0;
    sb_sample();
  endtask

  task automatic sb_done();
    chk("sb_drained", exp_pc_q.size(), 0);
    sb_en = 1'b0;
    exp_pc_q.delete();
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 16; i++) rom[i] = 8'hF0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_prog_addr"}, bus.prog_addr, 0);
    chk({tag, "_alu_ce"}, bus.alu_ce, 0);
    chk({tag, "_acc_we"}, bus.acc_we, 0);
    chk({tag, "_rf_we"}, bus.rf_we, 0);
    chk({tag, "_alu_op_code"}, bus.alu_op_code, 4'hF);
    chk({tag, "_rf_addr"}, bus.rf_addr, 0);
    chk({tag, "_alu_carry_in"}, bus.alu_carry_in, 0);
    chk({tag, "_carry_flag"}, carry_flag, 0);
    chk({tag, "_zero_flag"}, zero_flag, 0);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_stack_ovf"}, stack_ovf, 0);
    chk({tag, "_stack_unf"}, stack_unf, 0);
  endtask

  initial begin
    bus.alu_op_out    = 8'h01;
    bus.alu_carry_out = 1'b0;
    fill_nop();

    // instr, pre_c, pre_z, op_out, cout | ce, acc, rf, halt | pc, c, z, unf
    vecs.push_back('{8'h03, 0, 0, 8'h00, 1, 1, 1, 0, 0, 4'd2, 1, 1, 0});
    vecs.push_back('{8'h11, 1, 0, 8'h05, 0, 1, 1, 0, 0, 4'd2, 0, 0, 0});
    vecs.push_back('{8'h24, 0, 1, 8'h01, 1, 1, 1, 0, 0, 4'd2, 1, 0, 0});
    vecs.push_back('{8'h3F, 0, 0, 8'hFF, 1, 1, 1, 0, 0, 4'd2, 1, 0, 0});
    vecs.push_back('{8'h42, 1, 0, 8'h00, 0, 1, 1, 0, 0, 4'd2, 1, 1, 0});
    vecs.push_back('{8'h5A, 0, 1, 8'h3C, 1, 1, 1, 0, 0, 4'd2, 0, 0, 0});
    vecs.push_back('{8'h70, 1, 0, 8'h00, 0, 1, 1, 0, 0, 4'd2, 1, 1, 0});
    vecs.push_back('{8'h81, 0, 0, 8'h80, 1, 1, 1, 0, 0, 4'd2, 1, 0, 0});
    vecs.push_back('{8'h92, 1, 0, 8'h00, 0, 1, 1, 0, 0, 4'd2, 0, 1, 0});
    vecs.push_back('{8'hA5, 1, 0, 8'h00, 0, 1, 1, 0, 0, 4'd2, 1, 1, 0});
    vecs.push_back('{8'hB7, 1, 1, 8'h09, 0, 1, 0, 1, 0, 4'd2, 1, 1, 0});
    vecs.push_back('{8'hF3, 1, 0, 8'h00, 0, 0, 0, 0, 0, 4'd2, 1, 0, 0});
    vecs.push_back('{8'hD9, 0, 0, 8'h00, 1, 0, 0, 0, 0, 4'd9, 0, 0, 0});
    vecs.push_back('{8'hC0, 0, 1, 8'h05, 1, 0, 0, 0, 1, 4'd1, 0, 1, 0});
    vecs.push_back('{8'hE0, 1, 0, 8'h00, 0, 0, 0, 0, 0, 4'd2, 1, 0, RS});

    // Reset state while RST is held.
    @(negedge CLK);
    @(negedge CLK);
    chk_reset_outputs("reset");

    // Single-instruction vectors: ADD r0 preloads the flags, then the
    // instruction under test executes at PC 1 in cycle 5.
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      fill_nop();
      rom[0] = 8'h00;
      rom[1] = v.instr;
      bus.alu_op_out    = 8'h01;
      bus.alu_carry_out = 1'b0;
      start();
      run_to(2);
      bus.alu_op_out    = v.pre_z ? 8'h00 : 8'h01;
      bus.alu_carry_out = v.pre_c;
      run_to(3);
      bus.alu_op_out    = v.op_out;
      bus.alu_carry_out = v.cout;
      run_to(5);
      chk($sformatf("v%0d_alu_ce", i), bus.alu_ce, v.e_ce);
      chk($sformatf("v%0d_acc_we", i), bus.acc_we, v.e_acc);
      chk($sformatf("v%0d_rf_we", i), bus.rf_we, v.e_rf);
      chk($sformatf("v%0d_alu_carry_in", i), bus.alu_carry_in, v.pre_c);
      chk($sformatf("v%0d_pre_zero", i), zero_flag, v.pre_z);
      chk($sformatf("v%0d_alu_op_code", i), bus.alu_op_code, v.instr[7:4]);
      chk($sformatf("v%0d_rf_addr", i), bus.rf_addr, v.instr[3:0]);
      chk($sformatf("v%0d_halted_exec", i), halted, v.e_halt);
      run_to(6);
      chk($sformatf("v%0d_next_pc", i), bus.prog_addr, v.e_pc);
      chk($sformatf("v%0d_carry", i), carry_flag, v.e_c);
      chk($sformatf("v%0d_zero", i), zero_flag, v.e_z);
      chk($sformatf("v%0d_stack_unf", i), stack_unf, v.e_unf);
      chk($sformatf("v%0d_stack_ovf", i), stack_ovf, 0);
      chk($sformatf("v%0d_halted_after", i), halted, v.e_halt);
    end
    bus.alu_op_out    = 8'h01;
    bus.alu_carry_out = 1'b0;

    // LD r1, ADD r2, ST r3, HLT: strobe timing and absorbing HALT.
    fill_nop();
    rom[0] = mk(OP_LD, 4'd1);
    rom[1] = mk(OP_ADD, 4'd2);
    rom[2] = mk(OP_ST, 4'd3);
    rom[3] = mk(OP_HLT, 4'd0);
    exp_pc_q = '{4'd0, 4'd1, 4'd2, 4'd3};
    sb_en = 1'b1;
    start();
    for (int k = 0; k < 15; k++) begin
      if (k > 0) step();
      chk("p1_acc_we", bus.acc_we, (k == 2 || k == 5));
      chk("p1_rf_we", bus.rf_we, (k == 8));
      chk("p1_halted", halted, (k >= 11));
      if (k == 8) chk("p1_rf_addr", bus.rf_addr, 3);
      if (k >= 11) chk("p1_frozen_addr", bus.prog_addr, 3);
    end
    sb_done();

    // JMP 5 at PC 2, then NOPs run to PC F and wrap to 0.
    fill_nop();
    rom[2] = mk(OP_JMP, 4'd5);
    exp_pc_q = '{4'd0, 4'd1, 4'd2};
    for (int a = 5; a < 16; a++) exp_pc_q.push_back(4'(a));
    exp_pc_q.push_back(4'd0);
    sb_en = 1'b1;
    start();
    run_to(42);
    sb_done();

    // JMP 8 at PC 3, RTN at PC 8.
    fill_nop();
    rom[3] = mk(OP_JMP, 4'd8);
    rom[8] = mk(OP_RTN, 4'd0);
    exp_pc_q = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd8};
    exp_pc_q.push_back(RS ? 4'd4 : 4'd9);
    exp_pc_q.push_back(RS ? 4'd5 : 4'd10);
    sb_en = 1'b1;
    start();
    run_to(18);
    chk("rtn_stack_unf", stack_unf, 0);
    chk("rtn_stack_ovf", stack_ovf, 0);
    sb_done();

    // Five nested JMPs overflow a 4-deep stack; the fifth address is dropped.
    fill_nop();
    for (int a = 0; a < 5; a++) rom[a] = mk(OP_JMP, 4'(a + 1));
    rom[5] = mk(OP_RTN, 4'd0);
    exp_pc_q = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    exp_pc_q.push_back(RS ? 4'd4 : 4'd6);
    sb_en = 1'b1;
    start();
    run_to(12);
    chk("nest_ovf_before", stack_ovf, 0);
    run_to(15);
    chk("nest_ovf_after", stack_ovf, RS);
    run_to(18);
    chk("nest_ovf_sticky", stack_ovf, RS);
    chk("nest_unf", stack_unf, 0);
    sb_done();

    // Async reset in the middle of the ST execute cycle.
    fill_nop();
    rom[0] = mk(OP_LD, 4'd1);
    rom[1] = mk(OP_ADD, 4'd2);
    rom[2] = mk(OP_ST, 4'd3);
    rom[3] = mk(OP_HLT, 4'd0);
    bus.alu_op_out    = 8'h00;
    bus.alu_carry_out = 1'b1;
    start();
    run_to(8);
    chk("rst_pre_rf_we", bus.rf_we, 1);
    chk("rst_pre_carry", carry_flag, 1);
    chk("rst_pre_zero", zero_flag, 1);
    #2 RST = 1'b1;
    #1 chk_reset_outputs("midrst");
    bus.alu_op_out    = 8'h01;
    bus.alu_carry_out = 1'b0;
    exp_pc_q = '{4'd0, 4'd1, 4'd2};
    sb_en = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    cyc = 0;
    sb_sample();
    run_to(2);
    chk("restart_acc_we", bus.acc_we, 1);
    chk("restart_rf_addr", bus.rf_addr, 1);
    run_to(6);
    sb_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
